branch_resolve_queue: RTL and testbench

- Producer side of the predictor training interface: records each prediction made at fetch, then retires it in order when the branch resolves in execute.
- On retirement it compares actual vs predicted direction and drives the modify / increment strobe, plus a table index, to the 2-bit saturating-counter array.
- Raises a one-cycle mispredict pulse and discards all younger in-flight entries, since they are wrong-path.

---
 rtl/branch_pkg.sv | 17 +
 rtl/branch_resolve_queue.sv | 99 +++++++++
 tb/tb_branch_resolve_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch predictor training path.
package branch_pkg;

    localparam int BP_IDX_W       = 6;
    localparam int BP_QUEUE_DEPTH = 4;
    localparam int BP_CTR_W       = 2;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } bp_entry_t;

    function automatic logic bp_mispredicted(input logic predicted, input logic actual);
        return predicted != actual;
    endfunction

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time predictions; retires each on resolve, emits a
// counter-training strobe and squashes younger wrong-path entries on mispredict.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = BP_QUEUE_DEPTH,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic [IDX_W-1:0]           pred_idx,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    input  logic                       flush,
    output logic                       upd_modify,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_increment,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;
    logic               squash;
    entry_t             head;

    assign pred_ready = (count != CNT_W'(DEPTH));
    assign res_ready  = (count != '0);
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;
    assign head       = mem[rd_ptr];
    assign squash     = pop && bp_mispredicted(head.taken, res_taken);

    // NOTE: storage has no reset; occupancy is tracked by the pointers and
    // count alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !squash && !flush)
            mem[wr_ptr] <= '{idx: pred_idx, taken: pred_taken};
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (squash || flush) begin
                // Everything younger than the retiring branch is wrong-path.
                wr_ptr <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_modify    <= 1'b0;
            upd_idx       <= '0;
            upd_increment <= 1'b0;
            mispredict    <= 1'b0;
        end else begin
            upd_modify <= pop;
            mispredict <= squash;
            // Training follows the actual outcome, not the prediction.
            if (pop) begin
                upd_idx       <= head.idx;
                upd_increment <= res_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a reference queue model and an
// update scoreboard filled at stimulus time and drained on DUT output.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int IDX_W = 6;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             flush;
    logic             upd_modify;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_increment;
    logic             mispredict;
    logic [CW-1:0]    count;

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .flush(flush),
        .upd_modify(upd_modify), .upd_idx(upd_idx), .upd_increment(upd_increment),
        .mispredict(mispredict), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } ent_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             inc;
        logic             mis;
    } upd_t;

    ent_t             model[$];
    upd_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [IDX_W-1:0] last_idx = '0;
    logic             last_inc = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":count"},         32'(count),         32'd0);
        check({tag, ":upd_modify"},    32'(upd_modify),    32'd0);
        check({tag, ":upd_idx"},       32'(upd_idx),       32'd0);
        check({tag, ":upd_increment"}, 32'(upd_increment), 32'd0);
        check({tag, ":mispredict"},    32'(mispredict),    32'd0);
        check({tag, ":res_ready"},     32'(res_ready),     32'd0);
        check({tag, ":pred_ready"},    32'(pred_ready),    32'd1);
    endtask

    // Called just after a rising edge; drives one cycle and checks its result.
    task automatic step(input string tag, input logic pv, input logic [IDX_W-1:0] pi,
                        input logic pt, input logic rv, input logic rt, input logic fl);
        bit   do_push, do_pop, do_mis;
        ent_t head;
        upd_t u;
        pred_valid = pv; pred_idx = pi; pred_taken = pt;
        res_valid  = rv; res_taken = rt; flush = fl;
        #1;
        check({tag, ":pred_ready"}, 32'(pred_ready), 32'(model.size() != DEPTH));
        check({tag, ":res_ready"},  32'(res_ready),  32'(model.size() != 0));
        do_push = pv && (model.size() != DEPTH);
        do_pop  = rv && (model.size() != 0);
        do_mis  = 1'b0;
        if (do_pop) begin
            head   = model.pop_front();
            do_mis = (rt != head.taken);
            sb.push_back('{idx: head.idx, inc: rt, mis: do_mis});
        end
        if (do_mis || fl)
            model.delete();
        else if (do_push)
            model.push_back('{idx: pi, taken: pt});
        @(posedge clk);
        #1;
        check({tag, ":upd_modify"}, 32'(upd_modify), 32'(do_pop));
        if (do_pop) begin
            u        = sb.pop_front();
            last_idx = u.idx;
            last_inc = u.inc;
            check({tag, ":mispredict"}, 32'(mispredict), 32'(u.mis));
        end else begin
            check({tag, ":mispredict"}, 32'(mispredict), 32'd0);
        end
        check({tag, ":upd_idx"},       32'(upd_idx),       32'(last_idx));
        check({tag, ":upd_increment"}, 32'(upd_increment), 32'(last_inc));
        check({tag, ":count"},         32'(count),         32'(model.size()));
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single correct taken branch.
        step("t1_push", 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t1_res",  1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_idx5", 32'(upd_idx), 32'd5);

        // Fill, overfill, drain.
        for (int i = 1; i <= 4; i++)
            step("t2_fill", 1'b1, IDX_W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_full_ready", 32'(pred_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd4);
        step("t2_overfill", 1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_full_pushpop", 1'b1, 6'd63, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_first_idx", 32'(upd_idx), 32'd1);
        for (int i = 0; i < 3; i++)
            step("t2_drain", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_last_idx", 32'(upd_idx), 32'd4);

        // Mispredict squashes the younger entry.
        step("t3_push7", 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t3_push8", 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_mis",   1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_mis_pulse", 32'(mispredict), 32'd1);
        step("t3_idle",  1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_empty_res", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Mispredict with a simultaneous push drops the push.
        step("t4_push20", 1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_mis_push9", 1'b1, 6'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_count0", 32'(count), 32'd0);
        step("t4_push21", 1'b1, 6'd21, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_res21",  1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_idx21", 32'(upd_idx), 32'd21);

        // Flush together with a correct resolve.
        step("t5_push30", 1'b1, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_push31", 1'b1, 6'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_flush_res", 1'b1, 6'd32, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t5_empty_res", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_flush_only_push", 1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t5_push34", 1'b1, 6'd34, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_res34",  1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_idx34", 32'(upd_idx), 32'd34);

        // Asynchronous reset mid-stream.
        step("t6_push40", 1'b1, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_push41", 1'b1, 6'd41, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_push42", 1'b1, 6'd42, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_pop40",  1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t6_pop41",  1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async_rst");
        rst = 1'b0;
        model.delete();
        sb.delete();
        last_idx = '0;
        last_inc = 1'b0;
        step("t6_after_rst", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Wrap-around with overlapping push/pop pairs.
        step("t7_first", 1'b1, 6'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step("t7_pair", 1'b1, IDX_W'(50 + i), logic'(i % 2), 1'b1, logic'((i - 1) % 2), 1'b0);
        step("t7_last", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t7_last_idx", 32'(upd_idx), 32'd60);
        check("t7_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
